// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the pass FSM encoding, the mode constants and the word-count helpers.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    CCFF_IDLE = 2'd0,
    CCFF_RUN  = 2'd1,
    CCFF_DONE = 2'd2
  } ccff_state_e;

  localparam logic CCFF_MODE_LOAD  = 1'b0;
  localparam logic CCFF_MODE_CHECK = 1'b1;

  // Words needed to cover the whole chain in one pass.
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits of the final word that actually land in the chain.
  function automatic int last_word_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) between the bitstream source and the loader.
// The source drives the master modport; the loader consumes through the slave modport.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ccff_word_serializer.sv
// Word buffer for the chain loader: accepts stream words, shifts them out LSB first
// onto ccff_head and raises the shift enable while it still holds bits.
module ccff_word_serializer
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                clear,
  input  logic                run,
  ccff_chain_loader_if.slave  stream,
  output logic                head,
  output logic                shift_en
);

  localparam int NUM_WORDS = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int BC_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);

  // Masking the final word keeps discarded upper bits out of the buffer, so the
  // buffer reads all-zero (and head reads 0) whenever it is empty.
  localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);

  logic [WORD_W-1:0] word_buf;
  logic [BC_W-1:0]   bits_left;
  logic [WC_W-1:0]   words_taken;
  logic              more_words;
  logic              last_word;
  logic              take;

  assign more_words = (words_taken != WC_W'(NUM_WORDS));
  assign last_word  = (words_taken == WC_W'(NUM_WORDS - 1));
  assign shift_en   = run && (bits_left != '0);

  // A new word may arrive while the last buffered bit is leaving, giving
  // back-to-back words without a bubble.
  assign stream.s_ready = run && more_words &&
                          ((bits_left == '0) || ((bits_left == BC_W'(1)) && shift_en));
  assign take = stream.s_valid && stream.s_ready;

  assign head = word_buf[0];

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    // NOTE: word_buf is a plain register rather than a memory, so it is reset
    // along with the counts; ccff_head must read 0 straight out of reset.
    if (!pReset_n) begin
      word_buf    <= '0;
      bits_left   <= '0;
      words_taken <= '0;
    end else if (clear) begin
      word_buf    <= '0;
      bits_left   <= '0;
      words_taken <= '0;
    end else if (take) begin
      word_buf    <= last_word ? (stream.s_data & LAST_MASK) : stream.s_data;
      bits_left   <= last_word ? BC_W'(LAST_BITS) : BC_W'(WORD_W);
      words_taken <= words_taken + WC_W'(1);
    end else if (shift_en) begin
      word_buf    <= word_buf >> 1;
      bits_left   <= bits_left - BC_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: streams a bitstream into a ccff chain (LOAD) or
// re-streams it while comparing the chain tail against the bits sent (CHECK).
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                start,
  input  logic                mode,
  ccff_chain_loader_if.slave  stream,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    err_cnt
);

  ccff_state_e      state;
  ccff_state_e      next_state;
  logic             mode_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             start_pass;
  logic             last_shift;
  logic             mismatch;

  assign start_pass = (state == CCFF_IDLE) && start;
  assign last_shift = ccff_shift_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));

  // The chain already holds this stream, so the bit leaving the tail must equal
  // the bit entering the head on every shift of a CHECK pass.
  assign mismatch = (mode_q == CCFF_MODE_CHECK) && ccff_shift_en && (ccff_tail != ccff_head);

  assign busy = (state != CCFF_IDLE);
  assign done = (state == CCFF_DONE);

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_serializer (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .clear    (start_pass),
    .run      (state == CCFF_RUN),
    .stream   (stream),
    .head     (ccff_head),
    .shift_en (ccff_shift_en)
  );

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    // NOTE: non-blocking assignments in clocked processes make every flop
    // sample pre-edge values, whatever the statement order.
    if (!pReset_n) begin
      state <= CCFF_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: next_state gets its default before the case, so every path assigns
    // it and no latch is inferred.
    next_state = state;
    case (state)
      CCFF_IDLE: if (start)      next_state = CCFF_RUN;
      CCFF_RUN:  if (last_shift) next_state = CCFF_DONE;
      CCFF_DONE:                 next_state = CCFF_IDLE;
      default:                   next_state = CCFF_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      mode_q  <= CCFF_MODE_LOAD;
      bit_cnt <= '0;
    end else if (start_pass) begin
      mode_q  <= mode;
      bit_cnt <= '0;
    end else if (ccff_shift_en) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // err/err_cnt describe the last pass and hold through IDLE until the next start.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (start_pass) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != CNT_W'(CHAIN_LEN)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: two instances (24- and 20-bit chains)
// drive behavioural chain models; results are checked against hand-computed values.
module tb_ccff_chain_loader;
  import ccff_chain_loader_pkg::*;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset_n;
  logic [1:0] start_v;
  logic [1:0] mode_v;
  logic [1:0] valid_v;
  logic [7:0] data_v [2];
  logic [1:0] ready_v;
  logic [1:0] head_v;
  logic [1:0] shift_v;
  logic [1:0] tail_v;
  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [1:0] err_v;
  logic [4:0] errcnt_v [2];

  logic [23:0] chain0 = '0;
  logic [19:0] chain1 = '0;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  src_words [4];
  int          src_n;
  int          stall_idx;
  int          stall_len;
  logic [10:0] rst_snap;
  logic [23:0] chain_snap;

  ccff_chain_loader_if #(.WORD_W(8)) bus0 ();
  ccff_chain_loader_if #(.WORD_W(8)) bus1 ();

  assign bus0.s_data  = data_v[0];
  assign bus0.s_valid = valid_v[0];
  assign ready_v[0]   = bus0.s_ready;
  assign bus1.s_data  = data_v[1];
  assign bus1.s_valid = valid_v[1];
  assign ready_v[1]   = bus1.s_ready;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut0 (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start_v[0]),
    .mode          (mode_v[0]),
    .stream        (bus0),
    .ccff_head     (head_v[0]),
    .ccff_shift_en (shift_v[0]),
    .ccff_tail     (tail_v[0]),
    .busy          (busy_v[0]),
    .done          (done_v[0]),
    .err           (err_v[0]),
    .err_cnt       (errcnt_v[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut1 (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start_v[1]),
    .mode          (mode_v[1]),
    .stream        (bus1),
    .ccff_head     (head_v[1]),
    .ccff_shift_en (shift_v[1]),
    .ccff_tail     (tail_v[1]),
    .busy          (busy_v[1]),
    .done          (done_v[1]),
    .err           (err_v[1]),
    .err_cnt       (errcnt_v[1])
  );

  // Chain models: bit k of the stream lands at chain[k]; the tail is chain[0].
  always @(posedge prog_clk) if (shift_v[0]) chain0 <= {head_v[0], chain0[23:1]};
  always @(posedge prog_clk) if (shift_v[1]) chain1 <= {head_v[1], chain1[19:1]};
  assign tail_v[0] = chain0[0];
  assign tail_v[1] = chain1[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pass on instance d; returns the done cycle index (start cycle = 0),
  // shift cycles, accepted words and s_ready cycles seen after word 3 was taken.
  task automatic run_pass(input int d, input logic m, input int abort_at, input int restart_at,
                          output int cycles, output int shifts, output int acc,
                          output int late_ready);
    int widx;
    int stall_left;
    bit fin;
    widx = 0; stall_left = stall_len; cycles = 0; shifts = 0; acc = 0; late_ready = 0; fin = 0;
    mode_v[d]  = m;
    start_v[d] = 1'b1;
    @(posedge prog_clk); #1;
    start_v[d] = 1'b0;
    cycles = 1;
    while (!fin) begin
      start_v[d] = (cycles == restart_at);
      valid_v[d] = (widx < src_n) && !(widx == stall_idx && stall_left > 0);
      data_v[d]  = (widx < src_n) ? src_words[widx] : 8'h00;
      @(negedge prog_clk);
      if (abort_at > 0 && shifts == abort_at) begin
        pReset_n = 1'b0;
        #1;
        rst_snap   = {ready_v[d], head_v[d], shift_v[d], busy_v[d], done_v[d], err_v[d], errcnt_v[d]};
        chain_snap = chain0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        pReset_n = 1'b1;
        fin = 1;
      end else if (done_v[d]) begin
        fin = 1;
      end else if (cycles >= 100) begin
        cycles = 999;
        fin = 1;
      end else begin
        if (shift_v[d]) shifts++;
        if (ready_v[d] && widx >= 3) late_ready++;
        if (valid_v[d] && ready_v[d]) begin
          widx++;
          acc++;
        end else if (ready_v[d] && widx == stall_idx && stall_left > 0) begin
          stall_left--;
        end
        @(posedge prog_clk); #1;
        cycles++;
      end
    end
    start_v[d] = 1'b0;
    valid_v[d] = 1'b0;
    @(posedge prog_clk); #1;
  endtask

  initial begin
    int cyc, sh, acc, late;
    pReset_n = 1'b0;
    start_v = '0; mode_v = '0; valid_v = '0;
    data_v[0] = '0; data_v[1] = '0;
    src_n = 0; stall_idx = -1; stall_len = 0;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    check("reset_outputs_dut0", {ready_v[0], head_v[0], shift_v[0], busy_v[0], done_v[0], err_v[0], errcnt_v[0]}, 0);
    check("reset_outputs_dut1", {ready_v[1], head_v[1], shift_v[1], busy_v[1], done_v[1], err_v[1], errcnt_v[1]}, 0);
    pReset_n = 1'b1;
    @(posedge prog_clk); #1;

    // LOAD 0xA5,0x3C,0xFF, no stalls
    src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'hFF; src_words[3] = 8'h00; src_n = 3;
    run_pass(0, CCFF_MODE_LOAD, 0, 0, cyc, sh, acc, late);
    check("load_shift_cycles", sh, 24);
    check("load_done_cycle", cyc, 26);
    check("load_words", acc, 3);
    check("load_chain", chain0, 24'hFF3CA5);
    check("load_tail_ff", chain0[0], 1'b1);
    check("load_err", err_v[0], 1'b0);
    check("load_err_cnt", errcnt_v[0], 0);

    // CHECK with the same stream
    run_pass(0, CCFF_MODE_CHECK, 0, 0, cyc, sh, acc, late);
    check("check_ok_done_cycle", cyc, 26);
    check("check_ok_err", err_v[0], 1'b0);
    check("check_ok_err_cnt", errcnt_v[0], 0);
    check("check_ok_chain", chain0, 24'hFF3CA5);

    // CHECK with bit 0 and bit 23 flipped
    src_words[0] = 8'hA4; src_words[1] = 8'h3C; src_words[2] = 8'h7F;
    run_pass(0, CCFF_MODE_CHECK, 0, 0, cyc, sh, acc, late);
    check("check_bad_err", err_v[0], 1'b1);
    check("check_bad_err_cnt", errcnt_v[0], 2);
    check("check_bad_chain", chain0, 24'h7F3CA4);
    repeat (4) @(posedge prog_clk);
    #1;
    check("idle_err_hold", err_v[0], 1'b1);
    check("idle_err_cnt_hold", errcnt_v[0], 2);
    check("idle_busy", busy_v[0], 1'b0);

    // 20-bit chain: 3 words, upper nibble of word 3 dropped, 4th word never taken
    src_words[0] = 8'h5A; src_words[1] = 8'hC3; src_words[2] = 8'hF6; src_words[3] = 8'h99; src_n = 4;
    run_pass(1, CCFF_MODE_LOAD, 0, 0, cyc, sh, acc, late);
    check("short_words", acc, 3);
    check("short_shift_cycles", sh, 20);
    check("short_done_cycle", cyc, 22);
    check("short_chain", chain1, 20'h6C35A);
    check("short_late_ready", late, 0);

    // LOAD with s_valid withheld for 5 ready cycles after word 1
    src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'hFF; src_n = 3;
    stall_idx = 1; stall_len = 5;
    run_pass(0, CCFF_MODE_LOAD, 0, 0, cyc, sh, acc, late);
    stall_idx = -1; stall_len = 0;
    check("stall_shift_cycles", sh, 24);
    check("stall_done_cycle", cyc, 31);
    check("stall_chain", chain0, 24'hFF3CA5);
    check("stall_err_cleared", err_v[0], 1'b0);

    // Reset after 10 shifts of 0x12,0x34,0x56
    src_words[0] = 8'h12; src_words[1] = 8'h34; src_words[2] = 8'h56;
    run_pass(0, CCFF_MODE_LOAD, 10, 0, cyc, sh, acc, late);
    check("midreset_outputs", rst_snap, 0);
    check("midreset_chain_hold", chain0, chain_snap);
    check("midreset_chain", chain0, 24'h04BFCF);

    // Full LOAD afterwards, with a stray start pulse during RUN
    run_pass(0, CCFF_MODE_LOAD, 0, 12, cyc, sh, acc, late);
    check("reload_done_cycle", cyc, 26);
    check("reload_shift_cycles", sh, 24);
    check("reload_chain", chain0, 24'h563412);
    check("reload_err", err_v[0], 1'b0);
    check("reload_busy_after", busy_v[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
